// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALUOp/funct codes, EX control
// bit positions, mul/div FSM states and EX/MEM bubble values.
package mips_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_ADD2  = 3'b111;

  localparam int EX_REGDST = 4;
  localparam int EX_ALUSRC = 3;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [1:0] WB_BUBBLE  = 2'b00;
  localparam logic [4:0] MEM_BUBBLE = 5'b00000;

  // funct 0x18..0x1B; the low two bits then select mult/multu/div/divu
  function automatic logic is_muldiv(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide with HI/LO.
// state | meaning
// IDLE  | waiting for a start request
// RUN   | one shift-add or shift-subtract step per cycle
// DONE  | HI/LO just written; result retires this cycle
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            bzero_q, bzero_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic            start_ok, sgn, sa, sb;
  logic [XLEN:0]   mul_sum, div_shift;
  logic            div_ge;
  logic [XLEN-1:0] step_acc, step_sh, fin_hi, fin_lo;
  logic [2*XLEN-1:0] prod, prod_s;

  assign start_ok = start & ~abort & (state_q != MD_RUN);
  assign busy     = rst_n & ((state_q == MD_RUN) | ((state_q == MD_IDLE) & start & ~abort));
  assign done     = (state_q == MD_DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;

  assign sgn = ~op[0];
  assign sa  = sgn & a[XLEN-1];
  assign sb  = sgn & b[XLEN-1];

  // Magnitude datapath: acc is the product high half or the partial remainder
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, sh_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    if (is_div_q) begin
      step_acc = div_ge ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
      step_sh  = {sh_q[XLEN-2:0], div_ge};
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_sh  = {mul_sum[0], sh_q[XLEN-1:1]};
    end
    prod   = {step_acc, step_sh};
    prod_s = neg_res_q ? -prod : prod;
    if (is_div_q) begin
      fin_lo = bzero_q ? '1 : (neg_res_q ? -step_sh : step_sh);
      fin_hi = neg_rem_q ? -step_acc : step_acc;
    end else begin
      fin_lo = prod_s[XLEN-1:0];
      fin_hi = prod_s[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      MD_RUN: begin
        if (abort) begin
          state_d = MD_IDLE;
          count_d = '0;
        end else begin
          acc_d   = step_acc;
          sh_d    = step_sh;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = MD_DONE;
            count_d = '0;
            hi_d    = fin_hi;
            lo_d    = fin_lo;
          end
        end
      end
      default: begin
        if (start_ok) begin
          state_d   = MD_RUN;
          count_d   = '0;
          acc_d     = '0;
          sh_d      = sa ? -a : a;
          opnd_d    = sb ? -b : b;
          is_div_d  = op[1];
          neg_res_d = sa ^ sb;
          neg_rem_d = sa;
          bzero_d   = (b == '0);
        end else begin
          state_d = MD_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, operand select, branch target and the EX/MEM
// pipeline register, with an iterative mul/div unit that stalls upstream.
module ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [1:0]      wb_in,
  input  logic [4:0]      mem_in,
  input  logic [4:0]      ex_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rt_in,
  input  logic [4:0]      rd_in,
  input  logic [4:0]      shamt,
  output logic            busy,
  output logic            valid_out,
  output logic [1:0]      wb_out,
  output logic [4:0]      mem_out,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      dest_reg,
  output logic [XLEN-1:0] branch_target
);

  logic [2:0]      alu_op;
  logic [5:0]      funct;
  logic [XLEN-1:0] opb, imm_zx, alu_res;
  logic            md_start, md_busy, md_done;
  logic [XLEN-1:0] md_hi, md_lo;

  logic            valid_q, valid_d;
  logic [1:0]      wb_q, wb_d;
  logic [4:0]      mem_q, mem_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic [XLEN-1:0] store_q, store_d;
  logic [4:0]      dest_q, dest_d;
  logic [XLEN-1:0] bt_q, bt_d;

  assign alu_op   = ex_in[2:0];
  assign funct    = imm[5:0];
  assign opb      = ex_in[EX_ALUSRC] ? imm : rt_data;
  assign imm_zx   = {{(XLEN-16){1'b0}}, imm[15:0]};
  assign md_start = valid_in & (alu_op == ALU_RTYPE) & is_muldiv(funct);

  muldiv_unit #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (funct[1:0]),
    .a     (rs_data),
    .b     (rt_data),
    .abort (flush),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD, ALU_ADD2: alu_res = rs_data + opb;
      ALU_SUB:           alu_res = rs_data - opb;
      ALU_AND:           alu_res = rs_data & imm_zx;
      ALU_OR:            alu_res = rs_data | imm_zx;
      ALU_SLT:           alu_res = {{(XLEN-1){1'b0}}, $signed(rs_data) < $signed(opb)};
      ALU_LUI:           alu_res = imm_zx << 16;
      default: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_res = rs_data + opb;
          FN_SUB, FN_SUBU: alu_res = rs_data - opb;
          FN_AND:          alu_res = rs_data & opb;
          FN_OR:           alu_res = rs_data | opb;
          FN_XOR:          alu_res = rs_data ^ opb;
          FN_NOR:          alu_res = ~(rs_data | opb);
          FN_SLT:          alu_res = {{(XLEN-1){1'b0}}, $signed(rs_data) < $signed(opb)};
          FN_SLTU:         alu_res = {{(XLEN-1){1'b0}}, rs_data < opb};
          FN_SLL:          alu_res = rt_data << shamt;
          FN_SRL:          alu_res = rt_data >> shamt;
          FN_SRA:          alu_res = $unsigned($signed(rt_data) >>> shamt);
          FN_SLLV:         alu_res = rt_data << rs_data[4:0];
          FN_SRLV:         alu_res = rt_data >> rs_data[4:0];
          FN_SRAV:         alu_res = $unsigned($signed(rt_data) >>> rs_data[4:0]);
          FN_MFHI:         alu_res = md_hi;
          FN_MFLO:         alu_res = md_lo;
          default:         alu_res = '0;
        endcase
      end
    endcase
  end

  // Flush beats everything; a finishing mul/div retires with no register write
  always_comb begin
    valid_d = valid_in;
    wb_d    = valid_in ? wb_in : WB_BUBBLE;
    mem_d   = valid_in ? mem_in : MEM_BUBBLE;
    res_d   = alu_res;
    zero_d  = (alu_res == '0);
    store_d = rt_data;
    dest_d  = ex_in[EX_REGDST] ? rd_in : rt_in;
    bt_d    = pc_in + (imm << 2);
    if (flush || md_busy) begin
      valid_d = 1'b0;
      wb_d    = WB_BUBBLE;
      mem_d   = MEM_BUBBLE;
    end else if (md_done) begin
      valid_d = 1'b1;
      wb_d    = WB_BUBBLE;
      mem_d   = MEM_BUBBLE;
      res_d   = md_lo;
      zero_d  = (md_lo == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wb_q    <= '0;
      mem_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      store_q <= '0;
      dest_q  <= '0;
      bt_q    <= '0;
    end else begin
      valid_q <= valid_d;
      wb_q    <= wb_d;
      mem_q   <= mem_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      store_q <= store_d;
      dest_q  <= dest_d;
      bt_q    <= bt_d;
    end
  end

  assign busy          = md_busy;
  assign valid_out     = valid_q;
  assign wb_out        = wb_q;
  assign mem_out       = mem_q;
  assign alu_result    = res_q;
  assign zero          = zero_q;
  assign store_data    = store_q;
  assign dest_reg      = dest_q;
  assign branch_target = bt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table for single-cycle ops plus
// hand-written mul/div, flush and reset sequences with a result scoreboard.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid_in;
  logic [1:0]  wb_in;
  logic [4:0]  mem_in, ex_in, rt_in, rd_in, shamt;
  logic [31:0] pc_in, rs_data, rt_data, imm;
  logic        busy, valid_out, zero;
  logic [1:0]  wb_out;
  logic [4:0]  mem_out, dest_reg;
  logic [31:0] alu_result, store_data, branch_target;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(valid_in),
    .wb_in(wb_in), .mem_in(mem_in), .ex_in(ex_in), .pc_in(pc_in),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .rt_in(rt_in),
    .rd_in(rd_in), .shamt(shamt), .busy(busy), .valid_out(valid_out),
    .wb_out(wb_out), .mem_out(mem_out), .alu_result(alu_result),
    .zero(zero), .store_data(store_data), .dest_reg(dest_reg),
    .branch_target(branch_target)
  );

  localparam logic [4:0] RT_F = 5'd22;
  localparam logic [4:0] RD_F = 5'd11;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [1:0]  wb;
    logic [4:0]  mem;
    logic [4:0]  ex;
    logic [31:0] pc, rs, rt, imm;
    logic [4:0]  sh;
    logic        chk_data;
    logic [31:0] e_res;
    logic [31:0] e_bt;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [1:0]  wb;
    logic [4:0]  mem;
    logic        chk_data;
    logic [31:0] res;
    logic        zero;
    logic [31:0] st;
    logic [4:0]  dest;
    logic [31:0] bt;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] md_q[$];
  logic [63:0] last_hilo;

  function automatic vec_t mkv(input int i, input logic [4:0] ex, input logic [31:0] pc,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] im, input logic [4:0] sh,
                               input logic [31:0] e_res, input logic [31:0] e_bt);
    vec_t v;
    v.valid = 1'b1; v.wb = 2'(i); v.mem = 5'(i + 1); v.ex = ex; v.pc = pc;
    v.rs = rs; v.rt = rt; v.imm = im; v.sh = sh; v.chk_data = 1'b1;
    v.e_res = e_res; v.e_bt = e_bt;
    return v;
  endfunction

  function automatic logic [63:0] md_model(input logic [5:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] r;
    longint      la, lb;
    int          q, m;
    la = $signed(a);
    lb = $signed(b);
    case (fn)
      6'h18: r = la * lb;
      6'h19: r = {32'h0, a} * {32'h0, b};
      6'h1A: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = $signed(a) / $signed(b);
          m = $signed(a) % $signed(b);
          r = {m, q};
        end
      end
      default: r = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; flush = 1'b0; wb_in = '0; mem_in = '0; ex_in = '0;
    pc_in = '0; rs_data = '0; rt_data = '0; imm = '0; rt_in = RT_F; rd_in = RD_F; shamt = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_wb"},    wb_out, 0);
    chk({tag, "_mem"},   mem_out, 0);
    chk({tag, "_res"},   alu_result, 0);
    chk({tag, "_zero"},  zero, 0);
    chk({tag, "_st"},    store_data, 0);
    chk({tag, "_dest"},  dest_reg, 0);
    chk({tag, "_bt"},    branch_target, 0);
  endtask

  // single R-type op issued at edge+1, result sampled one edge later
  task automatic exec_r(input logic [5:0] fn, output logic [31:0] res);
    valid_in = 1'b1; ex_in = 5'h12; imm = {26'h0, fn}; rs_data = '0; rt_data = '0;
    wb_in = 2'b01; mem_in = '0;
    @(posedge clk); #1;
    chk("exec_valid", valid_out, 1);
    res = alu_result;
    valid_in = 1'b0;
  endtask

  task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    int          cyc;
    logic        finished;
    logic [63:0] e;
    logic [31:0] r;
    valid_in = 1'b1; ex_in = 5'h12; imm = {26'h0, fn}; rs_data = a; rt_data = b;
    wb_in = 2'b10; mem_in = '0;
    md_q.push_back(md_model(fn, a, b));
    cyc = 0; finished = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!busy) begin finished = 1'b1; break; end
      cyc++;
      if (cyc == 6) chk("md_run_bubble", {valid_out, wb_out}, 0);
      @(posedge clk); #1;
    end
    if (!finished) chk("md_busy_timeout", 1, 0);
    chk("md_busy_cycles", cyc, 33);
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk("md_retire_valid", valid_out, 1);
    chk("md_retire_wb", wb_out, 0);
    e = md_q.pop_front();
    exec_r(6'h12, r);
    chk("md_mflo", r, e[31:0]);
    exec_r(6'h10, r);
    chk("md_mfhi", r, e[63:32]);
    last_hilo = e;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt[22];
    exp_t        e;
    logic [31:0] r;

    vt[0]  = mkv(0,  5'h12, 32'h400, 32'h7FFF_FFFF, 32'h1, 32'h20, 5'd0, 32'h8000_0000, 32'h480);
    vt[1]  = mkv(1,  5'h01, 32'h100, 32'h5, 32'h5, 32'hFFFF_FFFE, 5'd0, 32'h0, 32'hF8);
    vt[2]  = mkv(2,  5'h12, 32'h0, 32'h3, 32'h5, 32'h22, 5'd0, 32'hFFFF_FFFE, 32'h88);
    vt[3]  = mkv(3,  5'h12, 32'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h24, 5'd0, 32'h00F0_1234, 32'h90);
    vt[4]  = mkv(4,  5'h12, 32'h0, 32'hF000_0000, 32'h0000_000F, 32'h25, 5'd0, 32'hF000_000F, 32'h94);
    vt[5]  = mkv(5,  5'h12, 32'h0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h26, 5'd0, 32'hF0F0_0F0F, 32'h98);
    vt[6]  = mkv(6,  5'h12, 32'h0, 32'h0, 32'h0, 32'h27, 5'd0, 32'hFFFF_FFFF, 32'h9C);
    vt[7]  = mkv(7,  5'h12, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h2A, 5'd0, 32'h1, 32'hA8);
    vt[8]  = mkv(8,  5'h12, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h2B, 5'd0, 32'h0, 32'hAC);
    vt[9]  = mkv(9,  5'h12, 32'h0, 32'h0, 32'h8000_000F, 32'h00, 5'd4, 32'h0000_00F0, 32'h0);
    vt[10] = mkv(10, 5'h12, 32'h0, 32'h0, 32'h8000_0000, 32'h02, 5'd4, 32'h0800_0000, 32'h8);
    vt[11] = mkv(11, 5'h12, 32'h0, 32'h0, 32'h8000_0000, 32'h03, 5'd4, 32'hF800_0000, 32'hC);
    vt[12] = mkv(12, 5'h12, 32'h0, 32'h21, 32'h8000_0000, 32'h07, 5'd0, 32'hC000_0000, 32'h1C);
    vt[13] = mkv(13, 5'h12, 32'h0, 32'h3, 32'h1, 32'h04, 5'd0, 32'h8, 32'h10);
    vt[14] = mkv(14, 5'h12, 32'h0, 32'h1, 32'h1, 32'h3F, 5'd0, 32'h0, 32'hFC);
    vt[15] = mkv(15, 5'h08, 32'h0, 32'hA, 32'h0, 32'hFFFF_FFFF, 5'd0, 32'h9, 32'hFFFF_FFFC);
    vt[16] = mkv(16, 5'h0B, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_8001, 5'd0, 32'h0000_8001, 32'hFFFE_0004);
    vt[17] = mkv(17, 5'h0C, 32'h0, 32'h1234_0000, 32'h0, 32'hFFFF_00FF, 5'd0, 32'h1234_00FF, 32'hFFFC_03FC);
    vt[18] = mkv(18, 5'h0D, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 5'd0, 32'h1, 32'hFFFF_FFFC);
    vt[19] = mkv(19, 5'h0E, 32'h0, 32'h0, 32'h0, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 32'h2AF34);
    vt[20] = mkv(20, 5'h0F, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1, 5'd0, 32'h0, 32'h4);
    vt[21] = mkv(21, 5'h12, 32'h0, 32'h1, 32'h1, 32'h20, 5'd0, 32'h2, 32'h80);
    vt[21].valid = 1'b0;
    vt[21].chk_data = 1'b0;

    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      valid_in = vt[i].valid; wb_in = vt[i].wb; mem_in = vt[i].mem; ex_in = vt[i].ex;
      pc_in = vt[i].pc; rs_data = vt[i].rs; rt_data = vt[i].rt; imm = vt[i].imm;
      shamt = vt[i].sh; rt_in = RT_F; rd_in = RD_F;
      e.valid = vt[i].valid;
      e.wb    = vt[i].valid ? vt[i].wb : 2'b00;
      e.mem   = vt[i].valid ? vt[i].mem : 5'b0;
      e.chk_data = vt[i].chk_data;
      e.res   = vt[i].e_res;
      e.zero  = (vt[i].e_res == 32'h0);
      e.st    = vt[i].rt;
      e.dest  = vt[i].ex[4] ? RD_F : RT_F;
      e.bt    = vt[i].e_bt;
      sb_q.push_back(e);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      chk($sformatf("vec%0d_valid", i), valid_out, e.valid);
      chk($sformatf("vec%0d_wb", i), wb_out, e.wb);
      chk($sformatf("vec%0d_mem", i), mem_out, e.mem);
      if (e.chk_data) begin
        chk($sformatf("vec%0d_res", i), alu_result, e.res);
        chk($sformatf("vec%0d_zero", i), zero, e.zero);
        chk($sformatf("vec%0d_store", i), store_data, e.st);
        chk($sformatf("vec%0d_dest", i), dest_reg, e.dest);
        chk($sformatf("vec%0d_bt", i), branch_target, e.bt);
      end
    end
    idle_inputs();
    @(posedge clk); #1;

    run_md(6'h18, 32'hFFFF_FFFD, 32'h7);
    run_md(6'h1A, 32'h7, 32'hFFFF_FFFE);
    run_md(6'h1B, 32'h5, 32'h0);
    run_md(6'h1A, 32'hFFFF_FFF9, 32'h2);
    run_md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md(6'h1A, 32'hFFFF_FFF9, 32'h0);

    // flush a multu partway through RUN
    valid_in = 1'b1; ex_in = 5'h12; imm = {26'h0, 6'h19}; rs_data = 32'hFFFF_FFFF;
    rt_data = 32'h2; wb_in = 2'b10; mem_in = 5'h3;
    repeat (11) @(posedge clk);
    #1;
    chk("flush_busy_before", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0;
    #1;
    chk("flush_busy_after", busy, 0);
    chk("flush_bubble", {valid_out, wb_out, mem_out}, 0);
    exec_r(6'h12, r);
    chk("flush_lo_kept", r, last_hilo[31:0]);
    exec_r(6'h10, r);
    chk("flush_hi_kept", r, last_hilo[63:32]);

    // reset in the middle of a divide
    valid_in = 1'b1; ex_in = 5'h12; imm = {26'h0, 6'h1A}; rs_data = 32'd100;
    rt_data = 32'd7; wb_in = 2'b10; mem_in = 5'h1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("rst_mid");
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    exec_r(6'h12, r);
    chk("rst_lo_cleared", r, 0);
    exec_r(6'h10, r);
    chk("rst_hi_cleared", r, 0);
    run_md(6'h1A, 32'd100, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ID/EX register outputs (WB/MEM/EX control, PC+4, register operands, sign-extended immediate, rt/rd, shamt).
- Produces the EX/MEM pipeline register: ALU result, zero flag, store data, destination register and branch target.
- Contains HI/LO and an iterative 32-cycle multiply/divide unit that stalls upstream stages while it runs.

Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iteration cycles per multiply or divide.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  squash the instruction in EX and abort any mul/div.
- valid_in  in  1  ID/EX holds a real instruction.
- wb_in  in  2  WB control, passed through.
- mem_in  in  5  MEM control, passed through.
- ex_in  in  5  [4] RegDst, [3] ALUSrc, [2:0] ALUOp.
- pc_in  in  32  PC+4 of the instruction.
- rs_data  in  32  read data 1.
- rt_data  in  32  read data 2.
- imm  in  32  sign-extended immediate; [5:0] = funct.
- rt_in  in  5  rt field.
- rd_in  in  5  rd field.
- shamt  in  5  shift amount.
- busy  out  1  stall request to PC, IF/ID and ID/EX.
- valid_out  out  1  EX/MEM holds a real instruction.
- wb_out  out  2  registered WB control.
- mem_out  out  5  registered MEM control.
- alu_result  out  32  registered ALU result.
- zero  out  1  registered (alu_result == 0).
- store_data  out  32  registered rt_data.
- dest_reg  out  5  registered rd_in if RegDst, else rt_in.
- branch_target  out  32  registered pc_in + (imm << 2).

Behaviour:
- Operand B = imm if ALUSrc, else rt_data.
- ALUOp encoding:
  - 000 add.
  - 001 sub.
  - 010 R-type by funct.
  - 011 and with zero-extended imm[15:0].
  - 100 or with zero-extended imm[15:0].
  - 101 slt.
  - 110 lui (imm[15:0] << 16).
  - 111 add.
- R-type funct codes:
  - 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu.
  - 00 sll, 02 srl, 03 sra (by shamt); 04 sllv, 06 srlv, 07 srav (by rs_data[4:0]).
  - 10 mfhi, 12 mflo.
  - 18 mult, 19 multu, 1A div, 1B divu.
  - Unknown funct yields result 0.
- All arithmetic wraps modulo 2^32; there are no overflow traps.
- EX/MEM register updates every cycle, so single-cycle ops have latency 1.
- Bubble = valid_out 0, wb_out 0, mem_out 0; data fields hold don't-care.
- Mul/div FSM states IDLE, RUN, DONE:
  - IDLE→RUN: valid_in and funct in {18..1B} and not flush. Latch operands and signedness; count←0. Signed ops work on magnitudes; signs are fixed at the end.
  - busy = (state==RUN) | (IDLE start condition), combinational. Busy is high for the accept cycle plus all RUN cycles (33 cycles total).
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle. When count==MD_CYCLES-1, write HI/LO and go to DONE.
  - DONE: busy 0. EX/MEM captures the mul/div as valid_out 1 with wb_out forced 00. Go to IDLE, or directly to RUN if a new mul/div is present.
  - While busy, EX/MEM captures bubbles.
- mfhi/mflo in the DONE cycle or later read the new HI/LO values.
- Result placement: mult/multu put the 64-bit product in HI:LO; div/divu put the quotient in LO and the remainder in HI.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: LO = FFFFFFFF, HI = dividend. Takes the full 32 cycles.
- flush:
  - Highest priority: EX/MEM captures a bubble and the FSM returns to IDLE.
  - HI/LO are unchanged, and busy drops the next cycle.
- Reset (also mid-operation):
  - All outputs 0, including busy.
  - HI = LO = 0, FSM in IDLE, count 0.

Decomposition:
- Package mips_pkg holds:
  - ALUOp and funct localparams.
  - EX control bit positions.
  - FSM state encoding (IDLE/RUN/DONE).
  - Bubble constants.
- Sub-module muldiv_unit holds the FSM, counter, shift/subtract datapath and HI/LO.
  - Interface: start, op[1:0], a, b, abort, busy, done, hi, lo.
- ALU and EX/MEM register stay in ex_stage.

Test Plan:
- add: rs=0x7FFFFFFF, rt=1, funct 20 → next cycle alu_result=0x80000000, zero=0, valid_out=1.
- beq: ALUOp 001, rs=rt=5, pc_in=0x100, imm=0xFFFFFFFE → zero=1, branch_target=0xF8.
- mult: rs=-3, rt=7 → busy high exactly 33 cycles. Then HI=FFFFFFFF, LO=FFFFFFEB. A following mflo returns FFFFFFEB.
- div: rs=7, rt=-2 → LO=FFFFFFFD, HI=1. divu 5/0 → LO=FFFFFFFF, HI=5.
- flush on iteration 10 of multu 0xFFFFFFFF*2 → busy drops the next cycle. HI/LO keep their prior values; bubble in EX/MEM.
- rst_n low mid-div → every output 0 next edge, including busy. A div issued afterwards completes correctly.
